uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 121 ++++++++++++
 tb/tb_uart_tx_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter; format and baud divisor are latched per frame
module uart_tx_param #(
    parameter int DIV_W      = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              divisor,
    input  logic [1:0]                    data_bits,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    input  logic [7:0]                    din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          Tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      level_q;
    logic [7:0]       data_q;
    logic [2:0]       last_q, bit_q, bit_d;
    logic [1:0]       par_q;
    logic             stop2_q, tx_q, line_d, push, load, tick;
    logic [DIV_W-1:0] div_q, cnt_q, cnt_d;

    assign push       = din_valid && din_ready;
    assign tick       = cnt_q == div_q - 1'b1;
    assign Tx         = tx_q;
    assign fifo_level = level_q;

    // state register, aborts any frame on reset
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state, frame load request and bit/baud counter updates
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        bit_d   = bit_q;
        cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                load    = level_q != '0;
                state_d = load ? START : IDLE;
            end
            START: begin
                bit_d   = '0;
                state_d = tick ? DATA : START;
            end
            DATA: if (tick) begin
                bit_d   = (bit_q == last_q) ? '0 : bit_q + 1'b1;
                state_d = (bit_q != last_q) ? DATA : (par_q[0] ^ par_q[1]) ? PARITY : STOP;
            end
            PARITY: state_d = tick ? STOP : PARITY;
            STOP: if (tick) begin
                bit_d = (bit_q == {2'b00, stop2_q}) ? '0 : bit_q + 1'b1;
                if (bit_q == {2'b00, stop2_q}) begin
                    load    = level_q != '0;
                    state_d = load ? START : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // line level for the current state plus status flags
    always_comb begin
        line_d    = (state_q == START)  ? 1'b0 :
                    (state_q == DATA)   ? data_q[bit_q] :
                    (state_q == PARITY) ? (^data_q) ^ par_q[1] : 1'b1;
        busy      = (state_q != IDLE) || (level_q != '0);
        din_ready = level_q < FULL;
    end

    // FIFO storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_q] <= din;
    end

    // FIFO pointers, frame config latch, counters and registered line output
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            data_q  <= '0;
            last_q  <= 3'd7;
            par_q   <= '0;
            stop2_q <= 1'b0;
            div_q   <= DIV_W'(2);
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (load) begin
                rd_q    <= rd_q + 1'b1;
                data_q  <= mem_q[rd_q] & (8'hFF >> (2'd3 - data_bits));
                last_q  <= {1'b1, data_bits};
                par_q   <= parity_mode;
                stop2_q <= stop2;
                div_q   <= (divisor < DIV_W'(2)) ? DIV_W'(2) : divisor;
            end
            level_q <= level_q + LW'(push) - LW'(load);
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= line_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: table-driven frames plus FIFO/reset corner sequences, checked by a serial-line scoreboard
module tb_uart_tx_param;
    logic        CLK, rst;
    logic [16:0] divisor;
    logic [1:0]  data_bits, parity_mode;
    logic        stop2;
    logic [7:0]  din;
    logic        din_valid, din_ready, Tx, busy;
    logic [2:0]  fifo_level;

    typedef struct {
        logic [11:0] pat;
        int          len;
        int          div;
    } exp_t;

    typedef struct {
        int          div;
        logic [1:0]  dbits;
        logic [1:0]  par;
        logic        s2;
        logic [7:0]  d;
        logic [11:0] pat;
        int          len;
    } vec_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_fail = 0, frames_done = 0;
    bit   mon_en = 0, check_gap = 0, in_frame = 0, need_start = 0;

    uart_tx_param dut (
        .CLK(CLK), .rst(rst), .divisor(divisor), .data_bits(data_bits),
        .parity_mode(parity_mode), .stop2(stop2), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .Tx(Tx), .busy(busy), .fifo_level(fifo_level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference frame: bits appended in line order, first bit ends up at pat[len-1]
    function automatic exp_t mk(input logic [7:0] d, input int n, input int pm, input bit s2, input int dv);
        exp_t e;
        logic p;
        e.pat = '0;
        e.len = 0;
        p     = 1'b0;
        e.pat = {e.pat[10:0], 1'b0}; e.len++;
        for (int i = 0; i < n; i++) begin
            e.pat = {e.pat[10:0], d[i]}; e.len++;
            p ^= d[i];
        end
        if (pm == 1 || pm == 2) begin
            e.pat = {e.pat[10:0], (pm == 2) ? ~p : p}; e.len++;
        end
        for (int i = 0; i < (s2 ? 2 : 1); i++) begin
            e.pat = {e.pat[10:0], 1'b1}; e.len++;
        end
        e.div = (dv < 2) ? 2 : dv;
        return e;
    endfunction

    task automatic set_cfg(input int dv, input logic [1:0] db, input logic [1:0] pm, input logic s2);
        divisor     = 17'(dv);
        data_bits   = db;
        parity_mode = pm;
        stop2       = s2;
    endtask

    task automatic push(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        @(posedge CLK);
        #1 din_valid = 1'b0;
    endtask

    task automatic push_sb(input logic [7:0] b, input exp_t e);
        exp_q.push_back(e);
        push(b);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !in_frame && !busy) break;
        end
        chk({name, " done"}, k < 3000, 1);
    endtask

    // serial monitor: every cycle of every bit period is checked against the scoreboard head
    initial begin
        exp_t it;
        int   bad;
        forever begin
            @(negedge CLK);
            if (need_start) begin
                need_start = 0;
                chk("b2b start", Tx, 0);
            end
            if (mon_en && !rst && Tx == 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("spurious start", Tx, 1);
                end else begin
                    it       = exp_q.pop_front();
                    in_frame = 1;
                    for (int b = 0; b < it.len; b++) begin
                        bad = 0;
                        for (int c = 0; c < it.div; c++) begin
                            if (b != 0 || c != 0) @(negedge CLK);
                            if (Tx !== it.pat[it.len-1-b]) bad++;
                        end
                        chk($sformatf("frame%0d bit%0d", frames_done, b), bad, 0);
                    end
                    frames_done++;
                    in_frame = 0;
                    if (check_gap && exp_q.size() != 0) need_start = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tv[6];
        int   k, fd0, bad;
        tv[0] = '{4, 2'b11, 2'b00, 1'b0, 8'hA5, 12'b0101001011, 10};
        tv[1] = '{3, 2'b10, 2'b10, 1'b1, 8'h41, 12'b01000001111, 11};
        tv[2] = '{2, 2'b00, 2'b01, 1'b0, 8'hFF, 12'b01111111, 8};
        tv[3] = '{5, 2'b01, 2'b11, 1'b1, 8'h2C, 12'b000110111, 9};
        tv[4] = '{1, 2'b11, 2'b01, 1'b0, 8'h00, 12'b00000000001, 11};
        tv[5] = '{3, 2'b11, 2'b10, 1'b0, 8'h80, 12'b00000000101, 11};

        rst = 1'b1; din = '0; din_valid = 1'b0;
        set_cfg(4, 2'b11, 2'b00, 1'b0);
        repeat (3) @(negedge CLK);
        chk("reset Tx", Tx, 1);
        chk("reset busy", busy, 0);
        chk("reset level", fifo_level, 0);
        chk("reset ready", din_ready, 1);
        rst    = 1'b0;
        mon_en = 1;

        // table of single frames; config is scrambled mid-frame to prove it is latched
        for (int i = 0; i < 6; i++) begin
            set_cfg(tv[i].div, tv[i].dbits, tv[i].par, tv[i].s2);
            push_sb(tv[i].d, '{tv[i].pat, tv[i].len, (tv[i].div < 2) ? 2 : tv[i].div});
            @(posedge CLK);
            #1;
            divisor     = 17'($urandom_range(0, 20));
            data_bits   = 2'($urandom);
            parity_mode = 2'($urandom);
            stop2       = 1'($urandom);
            wait_idle($sformatf("row%0d", i));
            @(negedge CLK);
            chk($sformatf("row%0d busy after", i), busy, 0);
            chk($sformatf("row%0d Tx idle", i), Tx, 1);
        end

        // FIFO fills while a frame runs; fifth push waits for the first pop
        set_cfg(2, 2'b11, 2'b00, 1'b0);
        check_gap = 1;
        fd0 = frames_done;
        push_sb(8'h10, mk(8'h10, 8, 0, 0, 2));
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 1; i <= 4; i++) push_sb(8'h10 + 8'(i), mk(8'h10 + 8'(i), 8, 0, 0, 2));
        chk("full level", fifo_level, 4);
        chk("full ready", din_ready, 0);
        exp_q.push_back(mk(8'h15, 8, 0, 0, 2));
        din = 8'h15; din_valid = 1'b1;
        k = 0;
        while (!din_ready && k < 100) begin
            @(posedge CLK);
            #1 k++;
        end
        chk("fifth push wait", k, 14);
        @(posedge CLK);
        #1 din_valid = 1'b0;
        chk("fifth accepted level", fifo_level, 4);
        wait_idle("burst");
        chk("burst frames", frames_done - fd0, 6);

        // divisor 0 runs at 2, a mid-frame change to 8 applies to the next frame only
        set_cfg(0, 2'b11, 2'b00, 1'b0);
        push_sb(8'h3C, '{12'b0001111001, 10, 2});
        @(posedge CLK);
        #1 divisor = 17'd8;
        push_sb(8'h5A, '{12'b0010110101, 10, 8});
        wait_idle("div change");
        check_gap = 0;

        // simultaneous push and pop at level 2
        set_cfg(2, 2'b11, 2'b00, 1'b0);
        push_sb(8'hC1, mk(8'hC1, 8, 0, 0, 2));
        push_sb(8'hC2, mk(8'hC2, 8, 0, 0, 2));
        push_sb(8'hC3, mk(8'hC3, 8, 0, 0, 2));
        chk("level before", fifo_level, 2);
        repeat (18) @(posedge CLK);
        #1 chk("level at pop-1", fifo_level, 2);
        push_sb(8'hC4, mk(8'hC4, 8, 0, 0, 2));
        chk("level push+pop", fifo_level, 2);
        wait_idle("push pop");

        // reset in the middle of DATA with two bytes queued
        mon_en = 0;
        set_cfg(4, 2'b11, 2'b00, 1'b0);
        push(8'h00); push(8'h00); push(8'h00);
        repeat (8) @(posedge CLK);
        #1;
        chk("pre-reset Tx", Tx, 0);
        chk("pre-reset level", fifo_level, 2);
        @(negedge CLK);
        rst = 1'b1;
        #1;
        chk("async reset Tx", Tx, 1);
        chk("async reset level", fifo_level, 0);
        chk("async reset busy", busy, 0);
        chk("async reset ready", din_ready, 1);
        @(negedge CLK);
        rst = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge CLK);
            if (Tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("quiet after reset", bad, 0);
        mon_en = 1;
        push_sb(8'h96, mk(8'h96, 8, 0, 0, 4));
        wait_idle("after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
